// File: rtl/param_memory_pkg.sv
// param_memory_pkg: state type and byte-lane merge helper shared by the memory files.
//   mem_state_t : ST_CLEAR while the zeroing sweep runs, ST_READY otherwise
//   lane_merge  : per-byte select of new over old data under a byte-enable mask
package param_memory_pkg;
    // Packages cannot be parametrised, so the helper works at a fixed maximum width;
    // callers zero-extend their operands and truncate the result.
    localparam int MAX_W = 256;
    localparam int MAX_B = MAX_W / 8;
    typedef enum logic {ST_CLEAR, ST_READY} mem_state_t;
    function automatic logic [MAX_W-1:0] lane_merge(
        input logic [MAX_W-1:0] old_w,
        input logic [MAX_W-1:0] new_w,
        input logic [MAX_B-1:0] be
    );
        logic [MAX_W-1:0] r;
        for (int i = 0; i < MAX_B; i++) r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/param_memory_array.sv
// param_memory_array: word storage with a byte-lane write port and an unregistered read port.
//   clk     : rising-edge clock
//   i_we    : write strobe
//   i_waddr : write address
//   i_wdata : write data
//   i_wbe   : byte-lane enables for the write
//   i_raddr : read address
//   o_rdata : combinational read of the pre-write contents
module param_memory_array
    import param_memory_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [ADDR_W-1:0]   i_waddr,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W/8-1:0] i_wbe,
    input  logic [ADDR_W-1:0]   i_raddr,
    output logic [DATA_W-1:0]   o_rdata
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= DATA_W'(lane_merge(MAX_W'(r_mem[i_waddr]), MAX_W'(i_wdata), MAX_B'(i_wbe)));
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/param_memory.sv
// param_memory: parametrised RAM with byte-lane writes, registered reads and a hardware clear sweep.
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset; starts a clear sweep
//   start     : global access enable
//   clear_req : restart the zeroing sweep
//   wr_*      : write request, address, data, byte enables
//   rd_*      : read request and address; rd_data/rd_valid follow one cycle later
//   busy      : sweep in progress, accesses ignored
module param_memory
    import param_memory_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int WR_FIRST = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                clear_req,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                busy
);
    mem_state_t          r_state;
    logic [ADDR_W-1:0]   r_clr_ptr;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;
    logic                r_busy;
    logic                w_clearing;
    logic                w_acc_ok;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic                w_arr_we;
    logic [ADDR_W-1:0]   w_arr_addr;
    logic [DATA_W-1:0]   w_arr_data;
    logic [DATA_W/8-1:0] w_arr_be;
    logic [DATA_W-1:0]   w_arr_rdata;
    logic [DATA_W-1:0]   w_rd_word;

    assign w_clearing = (r_state == ST_CLEAR);
    // A clear request wins over any access presented in the same cycle.
    assign w_acc_ok   = start & ~w_clearing & ~clear_req;
    assign w_wr_acc   = w_acc_ok & wr_en;
    assign w_rd_acc   = w_acc_ok & rd_en;

    // The sweep borrows the write port with all lanes enabled and zero data.
    assign w_arr_we   = w_clearing | w_wr_acc;
    assign w_arr_addr = w_clearing ? r_clr_ptr : wr_addr;
    assign w_arr_data = w_clearing ? '0 : wr_data;
    assign w_arr_be   = w_clearing ? '1 : wr_be;

    param_memory_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_waddr (w_arr_addr),
        .i_wdata (w_arr_data),
        .i_wbe   (w_arr_be),
        .i_raddr (rd_addr),
        .o_rdata (w_arr_rdata)
    );

    // The array read is pre-write, so old-data collisions need no special path.
    assign w_rd_word = (WR_FIRST != 0 && w_wr_acc && wr_addr == rd_addr)
                     ? DATA_W'(lane_merge(MAX_W'(w_arr_rdata), MAX_W'(wr_data), MAX_B'(wr_be)))
                     : w_arr_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_CLEAR;
            r_clr_ptr  <= '0;
            r_busy     <= 1'b1;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) r_rd_data <= w_rd_word;
            if (clear_req) begin
                r_state   <= ST_CLEAR;
                r_clr_ptr <= '0;
                r_busy    <= 1'b1;
            end else if (w_clearing) begin
                r_clr_ptr <= r_clr_ptr + 1'b1;
                if (&r_clr_ptr) begin
                    r_state <= ST_READY;
                    r_busy  <= 1'b0;
                end
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign busy     = r_busy;
endmodule

// File: tb/tb_param_memory.sv
// tb_param_memory: randomized and directed checks of param_memory against a word-level reference model.
module tb_param_memory;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int DEPTH    = 16;
    localparam int WR_FIRST = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        clear_req = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_mem [DEPTH];
    int          m_busy;
    logic [31:0] m_rd;
    logic        m_valid;

    always #5 clk = ~clk;

    param_memory #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .WR_FIRST (WR_FIRST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .clear_req (clear_req),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (n & m) | (o & ~m);
    endfunction

    // After any reset or clear the array is zero by the time reads are accepted again.
    task automatic model_clear;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_busy = DEPTH;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        #1;
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_data", rd_data, 32'd0);
        model_clear();
        m_valid = 1'b0;
        m_rd = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic step(input logic st, input logic cr, input logic we, input logic [3:0] wa,
                        input logic [31:0] wd, input logic [3:0] be, input logic re, input logic [3:0] ra);
        start = st; clear_req = cr; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra;
        @(posedge clk);
        if (m_busy > 0 || cr) begin
            m_valid = 1'b0;
            if (cr) model_clear();
            else m_busy--;
        end else begin
            m_valid = st & re;
            if (st & re) m_rd = (st && we && wa == ra && WR_FIRST != 0) ? merge(m_mem[ra], wd, be) : m_mem[ra];
            if (st & we) m_mem[wa] = merge(m_mem[wa], wd, be);
        end
        #1;
        chk("busy", 32'(busy), 32'(m_busy > 0));
        chk("rd_valid", 32'(rd_valid), 32'(m_valid));
        chk("rd_data", rd_data, m_rd);
    endtask

    task automatic idle;
        step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        step(1'b1, 1'b0, 1'b1, a, d, be, 1'b0, 4'd0);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, a);
    endtask

    initial begin
        #2;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            if (i == DEPTH - 2) chk("busy_15", 32'(busy), 32'd1);
            if (i == DEPTH - 1) chk("busy_16", 32'(busy), 32'd0);
        end
        rd(4'd5);
        chk("t1_valid", 32'(rd_valid), 32'd1);
        chk("t1_data", rd_data, 32'h0);

        for (int n = 0; n < DEPTH; n++) wr(4'(n), 32'(32'h11111111 * n), 4'hF);
        for (int n = 0; n < DEPTH; n++) begin
            rd(4'(n));
            chk("t2_data", rd_data, 32'(32'h11111111 * n));
        end

        wr(4'd3, 32'hFFFFFFFF, 4'hF);
        wr(4'd3, 32'h00AB0000, 4'b0100);
        rd(4'd3);
        chk("t3_lane", rd_data, 32'hFFABFFFF);

        wr(4'd7, 32'h77777777, 4'hF);
        step(1'b1, 1'b0, 1'b1, 4'd7, 32'h12345678, 4'hF, 1'b1, 4'd7);
        chk("t4_collide", rd_data, WR_FIRST != 0 ? 32'h12345678 : 32'h77777777);

        step(1'b0, 1'b0, 1'b1, 4'd2, 32'hDEADBEEF, 4'hF, 1'b1, 4'd2);
        chk("t5_nostart", 32'(rd_valid), 32'd0);
        rd(4'd2);
        chk("t5_keep", rd_data, 32'h22222222);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 63) == 0), 1'($urandom),
                 4'($urandom), $urandom, 4'($urandom), 1'($urandom), 4'($urandom_range(0, 3)));
        end

        while (m_busy > 0) idle();
        wr(4'd9, 32'hA5A5A5A5, 4'hF);
        rd(4'd9);
        chk("t6_pre_valid", 32'(rd_valid), 32'd1);
        do_reset();
        for (int i = 0; i < 8; i++) idle();
        do_reset();
        for (int i = 0; i < DEPTH; i++) idle();
        chk("t6_ready", 32'(busy), 32'd0);
        for (int n = 0; n < DEPTH; n++) wr(4'(n), 32'hC3C3C3C3 ^ 32'(n), 4'hF);
        rd(4'd4);
        step(1'b1, 1'b1, 1'b1, 4'd1, 32'h1, 4'hF, 1'b1, 4'd1);
        chk("t6_clr_valid", 32'(rd_valid), 32'd0);
        chk("t6_clr_busy", 32'(busy), 32'd1);
        for (int i = 0; i < DEPTH; i++) idle();
        for (int n = 0; n < DEPTH; n++) begin
            rd(4'(n));
            chk("t6_zero", rd_data, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
